// File: rtl/cloud_pkg.sv
// Shared types and helpers for the background sprite schedulers.
package cloud_pkg;

   localparam int unsigned MaxSlots = 8;
   // Fibonacci taps for x^10 + x^7 + 1 (bits 9 and 6 of the shift register).
   localparam logic [9:0] LFSR_TAPS = 10'h240;

   typedef struct packed {
      logic       active;
      logic [9:0] x;
      logic [9:0] y;
   } cloud_slot_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } free_slot_t;

   function automatic free_slot_t first_free(input logic [MaxSlots-1:0] active_vec);
      free_slot_t res;
      res = '0;
      for (int i = int'(MaxSlots) - 1; i >= 0; i--) begin
         if (!active_vec[i]) begin
            res.valid = 1'b1;
            res.idx   = 3'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR, shifting on every frame edge regardless of game state.
module lfsr10
   import cloud_pkg::*;
#(
   parameter logic [9:0] Seed = 10'h1A5
) (
   input  logic       Reset,
   input  logic       frame_clk,
   output logic [9:0] q_o
);

   logic [9:0] q_q, q_d;

   always_comb begin
      q_d = {q_q[8:0], ^(q_q & LFSR_TAPS)};
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         q_q <= Seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/cloud_scheduler.sv
// Fixed pool of cloud sprites: periodic spawn at the right edge, per-frame scroll,
// retire at the left edge.
module cloud_scheduler
   import cloud_pkg::*;
#(
   parameter int unsigned N_SLOTS      = 4,
   parameter int unsigned SPAWN_PERIOD = 120,
   parameter int unsigned X_START      = 639,
   parameter int unsigned Y_MIN        = 250,
   parameter int unsigned STEP         = 1,
   parameter logic [9:0]  LFSR_SEED    = 10'h1A5
) (
   input  logic                  Reset,
   input  logic                  frame_clk,
   input  logic                  run_i,
   input  logic                  clear_i,
   output logic [10*N_SLOTS-1:0] cloud_x_o,
   output logic [10*N_SLOTS-1:0] cloud_y_o,
   output logic [N_SLOTS-1:0]    cloud_active_o,
   output logic                  spawn_miss_o
);

   localparam int unsigned CntW = $clog2(SPAWN_PERIOD + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_PERIOD - 1);
   localparam logic [9:0] StepV  = 10'(STEP);
   localparam logic [9:0] XStart = 10'(X_START);
   localparam logic [9:0] YMin   = 10'(Y_MIN);

   cloud_slot_t [N_SLOTS-1:0] slots_q, slots_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      miss_q, miss_d;
   logic [9:0]                lfsr;
   logic [MaxSlots-1:0]       busy;
   free_slot_t                free;

   lfsr10 #(
      .Seed(LFSR_SEED)
   ) u_lfsr (
      .Reset    (Reset),
      .frame_clk(frame_clk),
      .q_o      (lfsr)
   );

   // Slots beyond the pool size are reported busy so they are never chosen.
   always_comb begin
      busy = '1;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         busy[i] = slots_q[i].active;
      end
      free = first_free(busy);
   end

   always_comb begin
      slots_d = slots_q;
      cnt_d   = cnt_q;
      miss_d  = 1'b0;
      if (clear_i) begin
         for (int i = 0; i < int'(N_SLOTS); i++) begin
            slots_d[i].active = 1'b0;
         end
         cnt_d = '0;
      end else if (run_i) begin
         for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (slots_q[i].active) begin
               if (slots_q[i].x < StepV) begin
                  slots_d[i].active = 1'b0;
               end else begin
                  slots_d[i].x = slots_q[i].x - StepV;
               end
            end
         end
         if (cnt_q == CntLast) begin
            cnt_d = '0;
            // The chosen slot was idle before this edge, so its scroll above was a no-op.
            if (free.valid) begin
               for (int i = 0; i < int'(N_SLOTS); i++) begin
                  if (free.idx == 3'(i)) begin
                     slots_d[i].active = 1'b1;
                     slots_d[i].x      = XStart;
                     slots_d[i].y      = YMin + {3'b000, lfsr[6:0]};
                  end
               end
            end else begin
               miss_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         slots_q <= '0;
         cnt_q   <= '0;
         miss_q  <= 1'b0;
      end else begin
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      cloud_x_o      = '0;
      cloud_y_o      = '0;
      cloud_active_o = '0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         cloud_x_o[10*i +: 10] = slots_q[i].x;
         cloud_y_o[10*i +: 10] = slots_q[i].y;
         cloud_active_o[i]     = slots_q[i].active;
      end
   end

   assign spawn_miss_o = miss_q;

endmodule
